// File: rtl/palm_locator_if.sv
// palm_locator_if: pixel-stream inputs and palm bounding-box results of the palm locator
//   object_image, pixel_valid, frame_start : raster pixel stream into the locator
//   start/end_of_palm_r/c, palm_width/height, palm_found, palm_valid : published frame result
interface palm_locator_if;
   logic       object_image;
   logic       pixel_valid;
   logic       frame_start;
   logic [7:0] start_of_palm_r;
   logic [7:0] start_of_palm_c;
   logic [7:0] end_of_palm_r;
   logic [7:0] end_of_palm_c;
   logic [7:0] palm_width;
   logic [7:0] palm_height;
   logic       palm_found;
   logic       palm_valid;
   modport master (
      output object_image, pixel_valid, frame_start,
      input  start_of_palm_r, start_of_palm_c, end_of_palm_r, end_of_palm_c,
             palm_width, palm_height, palm_found, palm_valid
   );
   modport slave (
      input  object_image, pixel_valid, frame_start,
      output start_of_palm_r, start_of_palm_c, end_of_palm_r, end_of_palm_c,
             palm_width, palm_height, palm_found, palm_valid
   );
endinterface

// File: rtl/palm_locator.sv
// palm_locator: finds the palm bounding box in a binary raster-scanned frame
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   px    : slave side of palm_locator_if (pixel stream in, box/size/found/valid out)
module palm_locator #(
   parameter int IMAGE_WIDTH     = 160,
   parameter int IMAGE_HEIGHT    = 120,
   parameter int ROW_MIN_PIXELS  = 4,
   parameter int MIN_PALM_HEIGHT = 8
) (
   input logic           clk,
   input logic           rst_n,
   palm_locator_if.slave px
);
   localparam logic [7:0] LAST_C  = 8'(IMAGE_WIDTH - 1);
   localparam logic [7:0] LAST_R  = 8'(IMAGE_HEIGHT - 1);
   localparam logic [7:0] MIN_CNT = 8'(ROW_MIN_PIXELS);
   localparam logic [7:0] MIN_H   = 8'(MIN_PALM_HEIGHT);
   typedef enum logic [1:0] {IDLE, SCAN, LATCH} state_e;
   state_e     state_q, state_d;
   logic [7:0] row_q, row_d, col_q, col_d, cnt_q, cnt_d, rmin_q, rmin_d, rmax_q, rmax_d;
   logic [7:0] top_q, top_d, bot_q, bot_d, lft_q, lft_d, rgt_q, rgt_d;
   logic       any_q, any_d;
   logic [7:0] sr_q, sr_d, sc_q, sc_d, er_q, er_d, ec_q, ec_d, w_q, w_d, h_q, h_d;
   logic       found_q, found_d;
   logic       start, take, white, row_end, last, qual, any_b, row_clr, ok;
   logic [7:0] row_e, col_e, cnt_b, rmin_b, rmax_b, cnt_n, rmin_n, rmax_n;
   logic [7:0] top_b, bot_b, lft_b, rgt_b;
   always_comb begin
      // a frame_start pixel restarts the scan at (0,0) from IDLE or mid-frame
      start   = px.pixel_valid && px.frame_start && state_q != LATCH;
      take    = start || (state_q == SCAN && px.pixel_valid);
      white   = px.object_image;
      row_e   = start ? 8'd0 : row_q;
      col_e   = start ? 8'd0 : col_q;
      row_clr = start || col_e == 8'd0;
      cnt_b   = row_clr ? 8'd0 : cnt_q;
      rmin_b  = row_clr ? 8'd0 : rmin_q;
      rmax_b  = row_clr ? 8'd0 : rmax_q;
      any_b   = start ? 1'b0 : any_q;
      top_b   = start ? 8'd0 : top_q;
      bot_b   = start ? 8'd0 : bot_q;
      lft_b   = start ? 8'd0 : lft_q;
      rgt_b   = start ? 8'd0 : rgt_q;
      row_end = col_e == LAST_C;
      last    = row_end && row_e == LAST_R;
      cnt_n   = (white && cnt_b != 8'hff) ? cnt_b + 8'd1 : cnt_b;
      rmin_n  = (white && cnt_b == 8'd0) ? col_e : rmin_b;
      rmax_n  = white ? col_e : rmax_b;
      qual    = row_end && cnt_n >= MIN_CNT;
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      cnt_d   = cnt_q;
      rmin_d  = rmin_q;
      rmax_d  = rmax_q;
      any_d   = any_q;
      top_d   = top_q;
      bot_d   = bot_q;
      lft_d   = lft_q;
      rgt_d   = rgt_q;
      sr_d    = sr_q;
      sc_d    = sc_q;
      er_d    = er_q;
      ec_d    = ec_q;
      w_d     = w_q;
      h_d     = h_q;
      found_d = found_q;
      if (take) begin
         row_d   = row_end ? row_e + 8'd1 : row_e;
         col_d   = row_end ? 8'd0 : col_e + 8'd1;
         cnt_d   = cnt_n;
         rmin_d  = rmin_n;
         rmax_d  = rmax_n;
         any_d   = any_b || qual;
         top_d   = (qual && (!any_b || row_e < top_b))  ? row_e  : top_b;
         bot_d   = (qual && (!any_b || row_e > bot_b))  ? row_e  : bot_b;
         lft_d   = (qual && (!any_b || rmin_n < lft_b)) ? rmin_n : lft_b;
         rgt_d   = (qual && (!any_b || rmax_n > rgt_b)) ? rmax_n : rgt_b;
         state_d = last ? LATCH : SCAN;
      end else if (state_q == LATCH) begin
         state_d = IDLE;
      end
      // results are registered on the last pixel so they are visible during LATCH
      ok = any_d && (bot_d - top_d + 8'd1) >= MIN_H;
      if (take && last) begin
         sr_d    = ok ? top_d : 8'd0;
         sc_d    = ok ? lft_d : 8'd0;
         er_d    = ok ? bot_d : 8'd0;
         ec_d    = ok ? rgt_d : 8'd0;
         w_d     = ok ? rgt_d - lft_d + 8'd1 : 8'd0;
         h_d     = ok ? bot_d - top_d + 8'd1 : 8'd0;
         found_d = ok;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         cnt_q   <= '0;
         rmin_q  <= '0;
         rmax_q  <= '0;
         any_q   <= 1'b0;
         top_q   <= '0;
         bot_q   <= '0;
         lft_q   <= '0;
         rgt_q   <= '0;
         sr_q    <= '0;
         sc_q    <= '0;
         er_q    <= '0;
         ec_q    <= '0;
         w_q     <= '0;
         h_q     <= '0;
         found_q <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         cnt_q   <= cnt_d;
         rmin_q  <= rmin_d;
         rmax_q  <= rmax_d;
         any_q   <= any_d;
         top_q   <= top_d;
         bot_q   <= bot_d;
         lft_q   <= lft_d;
         rgt_q   <= rgt_d;
         sr_q    <= sr_d;
         sc_q    <= sc_d;
         er_q    <= er_d;
         ec_q    <= ec_d;
         w_q     <= w_d;
         h_q     <= h_d;
         found_q <= found_d;
      end
   end
   assign px.start_of_palm_r = sr_q;
   assign px.start_of_palm_c = sc_q;
   assign px.end_of_palm_r   = er_q;
   assign px.end_of_palm_c   = ec_q;
   assign px.palm_width      = w_q;
   assign px.palm_height     = h_q;
   assign px.palm_found      = found_q;
   assign px.palm_valid      = state_q == LATCH;
endmodule

// File: tb/tb_palm_locator.sv
// tb_palm_locator: directed frames against the palm locator with hand-computed boxes
module tb_palm_locator;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   pulses = 0;
   palm_locator_if px();
   palm_locator dut (.clk(clk), .rst_n(rst_n), .px(px));
   always #5 clk = ~clk;
   always @(negedge clk) if (px.palm_valid) pulses++;
   localparam logic [48:0] RECT = {8'd40, 8'd50, 8'd79, 8'd99, 8'd50, 8'd40, 1'b1};
   localparam logic [48:0] NONE = '0;
   function automatic logic [48:0] result();
      return {px.start_of_palm_r, px.start_of_palm_c, px.end_of_palm_r, px.end_of_palm_c,
              px.palm_width, px.palm_height, px.palm_found};
   endfunction
   function automatic logic pix(input int kind, input int r, input int c);
      logic rect;
      rect = r >= 40 && r <= 79 && c >= 50 && c <= 99;
      if (kind == 1) return rect;
      if (kind == 2) return rect || (r == 10 && c >= 5 && c <= 7) || (r == 110 && c >= 140 && c <= 142);
      if (kind == 3) return r >= 20 && r <= 24 && c >= 30 && c <= 60;
      return 1'b0;
   endfunction
   // drives one frame; stop_row >= 0 abandons it before that row, use_fs=0 omits frame_start
   task automatic drive_frame(input int kind, input int gap, input int stop_row, input bit use_fs);
      for (int r = 0; r < 120; r++) begin
         if (r == stop_row) begin
            px.pixel_valid = 1'b0;
            px.frame_start = 1'b0;
            return;
         end
         for (int c = 0; c < 160; c++) begin
            while ($urandom_range(99) < gap) begin
               @(negedge clk);
               px.pixel_valid  = 1'b0;
               px.frame_start  = 1'($urandom_range(1));
               px.object_image = 1'($urandom_range(1));
            end
            @(negedge clk);
            #1;
            if (use_fs && r == 119 && c == 159) begin
               checks++;
               if (px.palm_valid !== 1'b0) begin
                  errors++;
                  $display("FAIL early_valid: got %b expected 0", px.palm_valid);
               end
            end
            px.pixel_valid  = 1'b1;
            px.object_image = pix(kind, r, c);
            px.frame_start  = use_fs && r == 0 && c == 0;
         end
      end
      @(negedge clk);
      #1;
      px.pixel_valid = 1'b0;
      px.frame_start = 1'b0;
      if (use_fs) begin
         checks++;
         if (px.palm_valid !== 1'b1) begin
            errors++;
            $display("FAIL valid_latency: got %b expected 1", px.palm_valid);
         end
         @(negedge clk);
         #1;
         checks++;
         if (px.palm_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_width: got %b expected 0", px.palm_valid);
         end
      end
   endtask
   task automatic test_reset();
      px.pixel_valid = 1'b0;
      px.frame_start = 1'b0;
      px.object_image = 1'b0;
      #12;
      checks++;
      if ({result(), px.palm_valid} !== 50'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", {result(), px.palm_valid});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic test_rect();
      int p0;
      p0 = pulses;
      drive_frame(1, 0, -1, 1);
      checks++;
      if (result() !== RECT) begin
         errors++;
         $display("FAIL rect_box: got %h expected %h", result(), RECT);
      end
      checks++;
      if (pulses - p0 !== 1) begin
         errors++;
         $display("FAIL rect_pulses: got %0d expected 1", pulses - p0);
      end
   endtask
   task automatic test_black();
      drive_frame(0, 0, -1, 1);
      checks++;
      if (result() !== NONE) begin
         errors++;
         $display("FAIL black_box: got %h expected %h", result(), NONE);
      end
   endtask
   task automatic test_specks();
      drive_frame(2, 0, -1, 1);
      checks++;
      if (result() !== RECT) begin
         errors++;
         $display("FAIL specks_box: got %h expected %h", result(), RECT);
      end
   endtask
   task automatic test_short_blob();
      drive_frame(3, 0, -1, 1);
      checks++;
      if (result() !== NONE) begin
         errors++;
         $display("FAIL blob_box: got %h expected %h", result(), NONE);
      end
   endtask
   task automatic test_restart();
      int p0;
      p0 = pulses;
      drive_frame(3, 0, 60, 1);
      drive_frame(1, 0, -1, 1);
      checks++;
      if (pulses - p0 !== 1) begin
         errors++;
         $display("FAIL restart_pulses: got %0d expected 1", pulses - p0);
      end
      checks++;
      if (result() !== RECT) begin
         errors++;
         $display("FAIL restart_box: got %h expected %h", result(), RECT);
      end
   endtask
   task automatic test_gaps_reset();
      int p0;
      drive_frame(1, 30, -1, 1);
      checks++;
      if (result() !== RECT) begin
         errors++;
         $display("FAIL gaps_box: got %h expected %h", result(), RECT);
      end
      p0 = pulses;
      drive_frame(1, 30, 50, 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({result(), px.palm_valid} !== 50'd0) begin
         errors++;
         $display("FAIL midframe_reset: got %h expected 0", {result(), px.palm_valid});
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive_frame(1, 0, -1, 0);
      @(negedge clk);
      checks++;
      if (pulses - p0 !== 0) begin
         errors++;
         $display("FAIL no_fs_pulses: got %0d expected 0", pulses - p0);
      end
      checks++;
      if (result() !== NONE) begin
         errors++;
         $display("FAIL no_fs_box: got %h expected %h", result(), NONE);
      end
      drive_frame(1, 0, -1, 1);
      checks++;
      if (pulses - p0 !== 1) begin
         errors++;
         $display("FAIL after_reset_pulses: got %0d expected 1", pulses - p0);
      end
      checks++;
      if (result() !== RECT) begin
         errors++;
         $display("FAIL after_reset_box: got %h expected %h", result(), RECT);
      end
   endtask
   initial begin
      test_reset();
      test_rect();
      test_black();
      test_specks();
      test_short_blob();
      test_restart();
      test_gaps_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
